// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding, default sizing and cycle-count helper for serial_subtractor
package sub_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 1;
  function automatic int cycles(input int w, input int dg);
    return w / dg;
  endfunction
endpackage

// File: rtl/full_sub.sv
// full_sub: single-bit full subtractor
// Ports: a minuend bit, b subtrahend bit, bin borrow in; diff difference bit, bout borrow out
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle ripple-borrow subtractor, d = {borrow, a - b}, DIGIT bits per cycle
// Ports: clk, rst (async, active-high); in_valid/in_ready + a/b operand handshake;
//        out_valid/out_ready + d result handshake; busy high while computing.
// Build option: APPROX_LSB_EN makes the low APPROX_BITS result bits a plain XOR with no borrow.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DIGIT       = DEF_DIGIT,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   d,
  output logic             busy
);
  localparam int N  = cycles(WIDTH, DIGIT);
  localparam int CW = $clog2(N + 1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   d_q, d_d;
  logic             bor_q, bor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] exact_diff, dig_diff;
  logic             approx;
`ifdef APPROX_LSB_EN
  assign approx = 32'(cnt_q) < APPROX_BITS / DIGIT;
`else
  assign approx = 1'b0;
`endif
  // approximate digits neither consume nor produce a borrow, so the cut above them starts clean
  assign chain[0] = bor_q & ~approx;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_sub u_cell (
      .a   (a_q[i]),
      .b   (b_q[i]),
      .bin (chain[i]),
      .diff(exact_diff[i]),
      .bout(chain[i+1])
    );
  end
  assign dig_diff  = approx ? a_q[DIGIT-1:0] ^ b_q[DIGIT-1:0] : exact_diff;
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q == BUSY;
  assign out_valid = state_q == DONE;
  assign d         = d_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    bor_d   = bor_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        bor_d   = 1'b0;
        cnt_d   = '0;
        state_d = BUSY;
      end
      // after the last digit one extra cycle places the final borrow as the sign bit
      BUSY: if (cnt_q == CW'(N)) begin
        d_d[WIDTH] = bor_q;
        state_d    = DONE;
      end else begin
        a_d              = a_q >> DIGIT;
        b_d              = b_q >> DIGIT;
        d_d[WIDTH-1:0]   = (d_q[WIDTH-1:0] >> DIGIT) | (WIDTH'(dig_diff) << (WIDTH - DIGIT));
        bor_d            = chain[DIGIT] & ~approx;
        cnt_d            = cnt_q + CW'(1);
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      bor_q   <= bor_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table + scoreboard bench for serial_subtractor (DIGIT=1 and DIGIT=4)
module tb_serial_subtractor;
  import sub_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] a, b;
  logic [16:0] d;
  logic        q_in_valid, q_in_ready, q_out_valid, q_out_ready, q_busy;
  logic [15:0] q_a, q_b;
  logic [16:0] q_d;
  int          errs = 0;
  int          checks = 0;
  logic [16:0] sb[$];
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] e;
    int          stall;
  } vec_t;
  vec_t vecs[8];
  always #5 clk = ~clk;
  serial_subtractor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .d(d), .busy(busy)
  );
  serial_subtractor #(.DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(q_in_valid), .in_ready(q_in_ready), .a(q_a), .b(q_b),
    .out_valid(q_out_valid), .out_ready(q_out_ready), .d(q_d), .busy(q_busy)
  );
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
`ifdef APPROX_LSB_EN
    logic [12:0] h;
    h = {1'b0, x[15:4]} - {1'b0, y[15:4]};
    return {h, x[3:0] ^ y[3:0]};
`else
    return {1'b0, x} - {1'b0, y};
`endif
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always begin
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 1);
      else chk("d", {15'd0, d}, {15'd0, sb.pop_front()});
    end
  end
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic [16:0] e,
                       input int stall);
    int n;
    logic [16:0] held;
    chk("in_ready_idle", {31'd0, in_ready}, 1);
    a = x;
    b = y;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    chk("busy_flags", {30'd0, in_ready, busy}, 32'b01);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 17);
    held = d;
    repeat (stall) begin
      @(negedge clk);
      chk("stall_hold", {13'd0, out_valid, in_ready, d}, {13'd0, 1'b1, 1'b0, held});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release", {30'd0, out_valid, in_ready}, 32'b01);
    out_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    q_in_valid = 1'b0;
    q_out_ready = 1'b1;
    q_a = '0;
    q_b = '0;
    vecs[0] = '{16'h1234, 16'h0034, 17'h01200, 0};
    vecs[1] = '{16'h0000, 16'h0001, model(16'h0000, 16'h0001), 0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 17'h00000, 0};
`ifdef APPROX_LSB_EN
    vecs[3] = '{16'h0010, 16'h0001, 17'h00011, 0};
`else
    vecs[3] = '{16'h0010, 16'h0001, 17'h0000F, 0};
`endif
    vecs[4] = '{16'h8000, 16'h0001, model(16'h8000, 16'h0001), 0};
    vecs[5] = '{16'h0001, 16'hFFFF, model(16'h0001, 16'hFFFF), 0};
    vecs[6] = '{16'hABCD, 16'h1234, model(16'hABCD, 16'h1234), 5};
    vecs[7] = '{16'h7FFF, 16'h8000, model(16'h7FFF, 16'h8000), 0};
    repeat (2) @(negedge clk);
    chk("reset_state", {12'd0, in_ready, out_valid, busy, d}, {12'd0, 1'b1, 1'b0, 1'b0, 17'd0});
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].stall);
    a = 16'h1111;
    b = 16'h2222;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("reset_mid_busy", {12'd0, in_ready, busy, out_valid, d}, {12'd0, 1'b1, 1'b0, 1'b0, 17'd0});
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("no_out_after_reset", n, 0);
    do_op(16'd5, 16'd3, model(16'd5, 16'd3), 0);
    q_a = 16'h8000;
    q_b = 16'h0001;
    q_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    q_in_valid = 1'b0;
    n = 0;
    while (!q_out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("d4_latency", n, 5);
    chk("d4_result", {15'd0, q_d}, {15'd0, model(16'h8000, 16'h0001)});
    @(negedge clk);
    chk("d4_idle", {31'd0, q_in_ready}, 1);
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
